// File: rtl/slc3_mem_responder_if.sv
// SLC-3 memory strobe bus plus preload port; master = CPU/boot side, slave = responder.
// Strobes are active low; read data, valid and error flag come back registered.
interface slc3_mem_responder_if #(
  parameter int ADDR_W = 10
);
  logic [15:0]       ADDR;
  logic              Mem_CE;
  logic              Mem_UB;
  logic              Mem_LB;
  logic              Mem_OE;
  logic              Mem_WE;
  logic [15:0]       Data_to_mem;
  logic [15:0]       Data_from_mem;
  logic              Rd_valid;
  logic              Err;
  logic              Ld_en;
  logic [ADDR_W-1:0] Ld_addr;
  logic [15:0]       Ld_data;

  modport master (
    output ADDR, Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE, Data_to_mem,
    output Ld_en, Ld_addr, Ld_data,
    input  Data_from_mem, Rd_valid, Err
  );

  modport slave (
    input  ADDR, Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE, Data_to_mem,
    input  Ld_en, Ld_addr, Ld_data,
    output Data_from_mem, Rd_valid, Err
  );
endinterface

// File: rtl/slc3_mem_responder.sv
// Byte-laned RAM answering SLC-3 CE/UB/LB/OE/WE strobes; read data valid READ_LAT edges after the strobe.
// No backpressure: one write per write strobe, preload always wins the single write port.
module slc3_mem_responder #(
  parameter int ADDR_W   = 10,
  parameter int READ_LAT = 1
) (
  input logic                 Clk,
  input logic                 Reset,
  slc3_mem_responder_if.slave bus
);

  localparam int         DEPTH = 1 << ADDR_W;
  localparam logic [2:0] LAT   = 3'(READ_LAT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RD_HOLD = 2'd2,
    WR_HOLD = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nxt;

  logic [15:0]       mem [DEPTH];

  logic              rd;
  logic              wr;
  logic              conflict;
  logic [ADDR_W-1:0] cpu_idx;
  logic [ADDR_W-1:0] lat_idx;
  logic [ADDR_W-1:0] rd_idx;
  logic              lat_ub;
  logic              lat_lb;
  logic              ub_sel;
  logic              lb_sel;
  logic [2:0]        cnt;
  logic [2:0]        cnt_inc;
  logic [15:0]       rd_word;
  logic [15:0]       rd_masked;
  logic [15:0]       data_q;
  logic              vld_q;
  logic              err_q;

  logic              start_rd;
  logic              capture;
  logic              cpu_wr;
  logic              err_set;
  logic              rd_hold;

  logic              unused_addr_hi;

  assign rd       = ~bus.Mem_CE & ~bus.Mem_OE &  bus.Mem_WE;
  assign wr       = ~bus.Mem_CE & ~bus.Mem_WE &  bus.Mem_OE;
  assign conflict = ~bus.Mem_CE & ~bus.Mem_OE & ~bus.Mem_WE;

  assign cpu_idx        = bus.ADDR[ADDR_W-1:0];
  assign unused_addr_hi = ^bus.ADDR[15:ADDR_W];
  assign cnt_inc        = cnt + 3'd1;

  // In IDLE a READ_LAT=1 read captures on its first edge, so use the live address and lanes.
  assign rd_idx    = (state == IDLE) ? cpu_idx      : lat_idx;
  assign ub_sel    = (state == IDLE) ? ~bus.Mem_UB  : lat_ub;
  assign lb_sel    = (state == IDLE) ? ~bus.Mem_LB  : lat_lb;
  assign rd_word   = mem[rd_idx];
  assign rd_masked = {ub_sel ? rd_word[15:8] : 8'h00, lb_sel ? rd_word[7:0] : 8'h00};

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (!bus.Ld_en) begin
          if (rd) begin
            state_nxt = (LAT == 3'd1) ? RD_HOLD : RD_WAIT;
          end else if (wr) begin
            state_nxt = WR_HOLD;
          end
        end
      end
      RD_WAIT: begin
        if (!bus.Mem_WE || !rd) begin
          state_nxt = IDLE;
        end else if (cnt_inc == LAT) begin
          state_nxt = RD_HOLD;
        end
      end
      RD_HOLD: begin
        if (!rd) begin
          state_nxt = IDLE;
        end
      end
      WR_HOLD: begin
        if (bus.Mem_WE || bus.Mem_CE || !bus.Mem_OE) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    start_rd = 1'b0;
    capture  = 1'b0;
    cpu_wr   = 1'b0;
    err_set  = 1'b0;
    rd_hold  = 1'b0;
    case (state)
      IDLE: begin
        if (!bus.Ld_en) begin
          err_set  = conflict;
          start_rd = rd;
          capture  = rd && (LAT == 3'd1);
          cpu_wr   = wr;
        end
      end
      RD_WAIT: begin
        err_set = ~bus.Mem_WE;
        capture = rd && (cnt_inc == LAT);
      end
      RD_HOLD: begin
        err_set = ~bus.Mem_WE;
        rd_hold = rd;
      end
      WR_HOLD: begin
        err_set = ~bus.Mem_OE & ~bus.Mem_WE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      data_q  <= 16'h0000;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
      cnt     <= 3'd0;
      lat_idx <= '0;
      lat_ub  <= 1'b0;
      lat_lb  <= 1'b0;
    end else begin
      err_q <= err_set;
      vld_q <= capture | rd_hold;
      if (start_rd) begin
        lat_idx <= cpu_idx;
        lat_ub  <= ~bus.Mem_UB;
        lat_lb  <= ~bus.Mem_LB;
        cnt     <= 3'd1;
      end else if (state == RD_WAIT && rd) begin
        cnt <= cnt_inc;
      end
      if (capture) begin
        data_q <= rd_masked;
      end
    end
  end

  // RAM is never reset; preload may land even while Reset is high.
  always_ff @(posedge Clk) begin
    if (bus.Ld_en) begin
      mem[bus.Ld_addr] <= bus.Ld_data;
    end else if (cpu_wr && !Reset) begin
      if (!bus.Mem_UB) begin
        mem[cpu_idx][15:8] <= bus.Data_to_mem[15:8];
      end
      if (!bus.Mem_LB) begin
        mem[cpu_idx][7:0] <= bus.Data_to_mem[7:0];
      end
    end
  end

  assign bus.Data_from_mem = data_q;
  assign bus.Rd_valid      = vld_q;
  assign bus.Err           = err_q;

endmodule

// File: doc/slc3_mem_responder.md
Name: slc3_mem_responder

Overview:
- Memory-side responder for the SLC-3 CPU memory interface; the target end of the active-low CE/UB/LB/OE/WE strobes driven by the control unit.
- Holds a word-addressed, byte-laned RAM and returns read data a fixed number of edges after the read strobe is first sampled.
- Commits exactly one write per write strobe.
- Provides a preload port so the bench or boot logic can load programs.

Parameters:
- ADDR_W, 10, RAM address width; depth = 2**ADDR_W words, CPU address bits above ADDR_W ignored.
- READ_LAT, 1, consecutive read-strobe edges before data is valid; legal 1..7.

Ports:
- Clk  in  1  system clock, all state on rising edge.
- Reset  in  1  synchronous, active-high reset.
- ADDR  in  16  CPU word address (from MAR).
- Mem_CE  in  1  chip enable, active low.
- Mem_UB  in  1  upper-byte enable (bits 15:8), active low.
- Mem_LB  in  1  lower-byte enable (bits 7:0), active low.
- Mem_OE  in  1  output/read enable, active low.
- Mem_WE  in  1  write enable, active low.
- Data_to_mem  in  16  write data (from MDR).
- Data_from_mem  out  16  registered read data.
- Rd_valid  out  1  Data_from_mem holds the current read's result.
- Err  out  1  registered one-cycle protocol-violation flag.
- Ld_en  in  1  preload write request.
- Ld_addr  in  ADDR_W  preload address.
- Ld_data  in  16  preload data, full word.

Behaviour:
- Clock/reset: one clock Clk; Reset is synchronous, active-high.
- On Reset: state IDLE, Data_from_mem=0, Rd_valid=0, Err=0, read counter=0. RAM contents are not cleared.
- Strobe decode at each edge:
  - RD = ~CE & ~OE & WE.
  - WR = ~CE & ~WE & OE.
  - CONFLICT = ~CE & ~OE & ~WE.
- States: IDLE, RD_WAIT, RD_HOLD, WR_HOLD.
- IDLE:
  - Ld_en=1: preload write Ld_data->RAM[Ld_addr]; any CPU strobe is ignored this edge and FSM stays IDLE. A held strobe is taken at the next edge with Ld_en=0.
  - CONFLICT: no RAM access, Err=1 next cycle, stay IDLE.
  - RD: latch ADDR[ADDR_W-1:0] and lane enables, counter=1. If READ_LAT=1, capture data and go RD_HOLD; else go RD_WAIT.
  - WR: write Data_to_mem to RAM[ADDR] for enabled lanes only, go WR_HOLD. UB=LB=1 is a legal write with no RAM change.
- RD_WAIT:
  - RD still true: counter++. When counter reaches READ_LAT, capture data and go RD_HOLD.
  - RD false (OE or CE released): abort to IDLE, Rd_valid stays 0.
  - ~WE sampled low: abort to IDLE, Err=1.
- Data capture:
  - Data_from_mem = RAM[latched addr], with disabled-lane bytes forced to 0x00.
  - Rd_valid=1 in the cycle after the capture edge.
  - Read-before-write: a same-edge preload to the same address returns the old data.
- RD_HOLD:
  - Data_from_mem and Rd_valid held while RD is true; address changes are ignored.
  - RD false: go IDLE, Rd_valid=0 next cycle, Data_from_mem retains its last value.
  - WE low: IDLE plus Err pulse.
- WR_HOLD:
  - Stay while WE=0 & CE=0; no further writes.
  - Release: IDLE.
  - OE low while WE low: Err pulse, go IDLE. No second write.
- Timing: for READ_LAT=1, OE held low two cycles gives valid data in the second cycle, i.e. LD_MDR timing.
- Preload: Ld_en writes in every state. The only RAM write port is shared, so CPU writes happen only in IDLE with Ld_en=0.
- Err: high for exactly one cycle per offending edge.
- Reset mid-access: returns to IDLE on that edge. A write already committed stays committed.

Test Plan:
1. Preload RAM[0x005]=0x1234; hold CE=0, OE=0 at ADDR=0x0005 for 2 cycles (READ_LAT=1) -> Data_from_mem=0x1234, Rd_valid=1 in the 2nd cycle; OE high -> Rd_valid=0 next cycle, data still 0x1234.
2. Preload 0xFFFF at 0x010; write strobe 3 cycles with LB=0, UB=1, data 0xABCD -> exactly one write; readback with both lanes gives 0xFFCD; read with UB only gives 0xFF00.
3. READ_LAT=3; OE low for 2 edges then released -> Rd_valid never asserts; a repeat read held 3 edges -> valid after the 3rd edge.
4. CE=0, OE=0, WE=0 in IDLE -> Err=1 for one cycle, RAM unchanged, state IDLE; WE dropped during RD_HOLD -> Err pulse, Rd_valid=0.
5. Ld_en=1 at 0x020 with data 0x5555 in the same cycle as a CPU write to 0x020 with 0x7777, held 2 cycles -> preload at edge 1, CPU write at edge 2; final value 0x7777.
6. Reset asserted during RD_WAIT -> next cycle Rd_valid=0, Data_from_mem=0, Err=0; RAM contents preserved on readback.
